// File: rtl/pattern_blinker.sv
// pattern_blinker: multi-channel LED pattern sequencer driven by a shared bit-rate prescaler
// Ports: CLK, reset (async, active-low); bit_period = clocks per pattern bit minus 1 (live);
//   cfg_valid/cfg_ready handshake with cfg_chan, cfg_pattern (bit 0 first), cfg_len (last index),
//   cfg_oneshot; led, busy (channel running), done (one-cycle pulse when a one-shot ends).
// Optional BLINK_PWM_EN: adds an 8-bit duty input that gates led with a free-running PWM counter.
module pattern_blinker #(
  parameter int CHANNELS = 1,
  parameter int PAT_W = 32,
  parameter int DIV_W = 26,
  parameter logic [PAT_W-1:0] DEFAULT_PATTERN = PAT_W'(32'h0151DDC5),
  parameter int DEFAULT_LEN = 26,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LEN_W = $clog2(PAT_W)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [DIV_W-1:0]    bit_period,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [PAT_W-1:0]    cfg_pattern,
  input  logic [LEN_W:0]      cfg_len,
  input  logic                cfg_oneshot,
`ifdef BLINK_PWM_EN
  input  logic [7:0]          duty,
`endif
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  logic [DIV_W-1:0] r_cnt;
  logic w_tick, w_pwm_on;
  logic [CHANNELS-1:0] w_block;
  logic [LEN_W-1:0] w_len_cl;
  assign w_tick = r_cnt >= bit_period;
  assign w_len_cl = (cfg_len > (LEN_W+1)'(PAT_W-1)) ? LEN_W'(PAT_W-1) : cfg_len[LEN_W-1:0];
  // an out-of-range channel matches no w_block bit, so it is always ready and silently dropped
  assign cfg_ready = ~|w_block;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
`ifdef BLINK_PWM_EN
  logic [7:0] r_pwm;
  assign w_pwm_on = r_pwm < duty;
  always_ff @(posedge CLK or negedge reset)
    if (!reset) r_pwm <= '0;
    else r_pwm <= r_pwm + 1'b1;
`else
  assign w_pwm_on = 1'b1;
`endif
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t r_state, w_state;
    logic [PAT_W-1:0] r_pat, w_pat, r_sh_pat;
    logic [LEN_W-1:0] r_len, w_len, r_idx, w_idx, r_sh_len;
    logic r_os, w_os, r_sh_os, r_pend, r_prime, r_seq, w_seq, r_led, r_done, w_done, w_hit, w_xfer;
    assign w_hit = cfg_chan == CH_W'(g);
    assign w_xfer = cfg_valid & w_hit & ~r_pend;
    assign w_block[g] = w_hit & r_pend;
    assign led[g] = r_led;
    assign busy[g] = r_state == S_RUN;
    assign done[g] = r_done;
    // r_prime marks the reset-loaded pattern whose bit 0 has not been shown yet
    always_comb begin
      w_state = r_state;
      w_pat = r_pat;
      w_len = r_len;
      w_os = r_os;
      w_idx = r_idx;
      w_seq = r_seq;
      w_done = 1'b0;
      if (w_tick) begin
        if (r_pend) begin
          w_state = S_RUN;
          w_pat = r_sh_pat;
          w_len = r_sh_len;
          w_os = r_sh_os;
          w_idx = '0;
          w_seq = r_sh_pat[0];
        end else if (r_state == S_IDLE) w_seq = 1'b0;
        else if (r_prime) w_seq = r_pat[0];
        else if (r_idx != r_len) begin
          w_idx = r_idx + 1'b1;
          w_seq = r_pat[w_idx];
        end else if (r_os) begin
          w_state = S_IDLE;
          w_seq = 1'b0;
          w_done = 1'b1;
        end else begin
          w_idx = '0;
          w_seq = r_pat[0];
        end
      end
    end
    always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
        r_state <= (g == 0) ? S_RUN : S_IDLE;
        r_pat <= (g == 0) ? DEFAULT_PATTERN : '0;
        r_len <= (g == 0) ? LEN_W'(DEFAULT_LEN) : '0;
        r_os <= 1'b0;
        r_idx <= '0;
        r_seq <= 1'b0;
        r_led <= 1'b0;
        r_done <= 1'b0;
        r_pend <= 1'b0;
        r_prime <= (g == 0);
        r_sh_pat <= '0;
        r_sh_len <= '0;
        r_sh_os <= 1'b0;
      end else begin
        r_state <= w_state;
        r_pat <= w_pat;
        r_len <= w_len;
        r_os <= w_os;
        r_idx <= w_idx;
        r_seq <= w_seq;
        r_led <= w_seq & w_pwm_on;
        r_done <= w_done;
        r_prime <= r_prime & ~w_tick;
        // a capture never coincides with an already-pending entry, so set wins without bypass
        r_pend <= w_xfer | (r_pend & ~w_tick);
        if (w_xfer) begin
          r_sh_pat <= cfg_pattern;
          r_sh_len <= w_len_cl;
          r_sh_os <= cfg_oneshot;
        end
      end
  end
endmodule
